rule110_seed_loader: RTL and testbench
======================================

Name: rule110_seed_loader

Overview:
- Upstream feeder for the 512-cell rule-110 automaton (ports clk, load, data[511:0], q[511:0]).
- Accepts a seed as a stream of narrow words over a valid/ready handshake and assembles it into the wide data bus.
- Then pulses load to seed the automaton, and reports completion.
- Frees the host from driving a 512-bit bus directly; short frames are zero-extended, so a single-cell seed is one word.

Parameters:
- WIDTH, 512, cell count; width of data. Must be a multiple of WORD.
- WORD, 32, input word width.
- LOAD_CYCLES, 1, number of consecutive cycles load is held high per frame (>=1).
- Derived: NWORDS = WIDTH/WORD (16); counter width clog2(NWORDS).

Ports:
- clk  in  1  rising-edge clock, shared with the automaton.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  WORD  seed word; the first word of a frame is the least significant.
- in_last  in  1  marks the final word of a frame.
- load  out  1  to automaton load.
- data  out  WIDTH  to automaton data.
- busy  out  1  frame in progress (a word has been accepted, or load phase active).
- done  out  1  one-cycle pulse after the load phase ends.
- err_len  out  1  one-cycle pulse: the NWORDS-th word was accepted without in_last.

Behaviour:
- Reset (async assert, sync release):
  - state=FILL, cnt=0, data=0, load=0, done=0, err_len=0.
  - in_ready forced 0 while reset is high.
- Accept event: in_valid & in_ready at a rising edge. in_ready is combinational: high in FILL, low otherwise.
- FILL, accept with cnt==0:
  - data <= zero-extended in_data (the entire previous seed is cleared).
  - Otherwise data[cnt*WORD +: WORD] <= in_data.
  - cnt increments.
- Frame end: accept with in_last=1 or cnt==NWORDS-1.
  - cnt <= 0; state <= LOAD; load counter <= 0.
  - Words not received stay zero.
- Length error: accept with cnt==NWORDS-1 and in_last=0.
  - err_len pulses 1 cycle, coincident with the first load cycle.
  - The frame is still loaded. The next word starts a new frame.
- LOAD:
  - load=1 (registered) for exactly LOAD_CYCLES cycles, starting the cycle after the final accept edge.
  - in_ready=0 throughout; in_valid is ignored.
- After the last load cycle: state <= FILL, done=1 for one cycle. in_ready returns high in that same cycle.
- data stability:
  - data is held stable from the final accept edge through the entire load phase.
  - After that, data changes only on the next frame's first accept.
- Latency:
  - Final word accept at edge E -> load high cycles E+1..E+LOAD_CYCLES.
  - done high in cycle E+LOAD_CYCLES+1.
  - Minimum frame period = words + LOAD_CYCLES + 0 idle cycles. A new first word may be accepted in the done cycle.
- busy = (state==LOAD) | (cnt!=0).
- in_valid low mid-frame: loader waits indefinitely, with no timeout.
- in_last on the first word: single-word frame. This is legal.
- Reset mid-frame or mid-load:
  - load drops immediately (asynchronous).
  - The partial frame is discarded and data is cleared.
  - No done or err_len pulse.
- in_data/in_last are sampled only on accept. X on them without in_valid must not propagate.

Test Plan:
- Single word 0x00000001 with in_last -> data=={511'b0,1'b1}; load high exactly 1 cycle (LOAD_CYCLES=1) starting one edge after accept; done pulses the next cycle; automaton q shows 0x...0003 one cycle after load falls.
- 16 words 0x00000000..0x0000000F with in_last on word 15, in_valid held high -> data[31:0]=0, data[511:480]=0xF; err_len stays 0; in_ready low during load.
- 16 words with no in_last -> err_len pulses with load; a 17th word 0xAAAAAAAA starts a new frame: data==zero-extended 0xAAAAAAAA after accept.
- Back-to-back frames: first frame 0x7 (1 word), second frame 0xFFFFFFFF,0x1 (2 words), offered in the done cycle -> accepted with no gap; second load sees data[63:0]=0x00000001FFFFFFFF and all upper bits zero.
- in_valid gaps of 3 cycles between words, LOAD_CYCLES=4 -> data unchanged until final accept; load high exactly 4 cycles; busy high from first accept until done.
- Assert reset after 5 of 16 words, then during a load phase -> load falls within the reset cycle; data==0; no done; next frame starts at cnt=0.

Source files
------------

// File: rtl/rule110_seed_loader.sv
// Seed loader for the rule-110 automaton: assembles a stream of narrow words
// into the wide data bus, pulses load for LOAD_CYCLES cycles and reports done.
module rule110_seed_loader #(
    parameter int WIDTH       = 512,
    parameter int WORD        = 32,
    parameter int LOAD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WORD-1:0]  in_data,
    input  logic             in_last,
    output logic             load,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             err_len
);

    localparam int NWORDS = WIDTH / WORD;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int LW     = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(NWORDS - 1);
    localparam logic [LW-1:0] LCNT_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LCNT_ONE  = LW'(1);
    localparam logic [LW-1:0] LCNT_LAST = LW'(LOAD_CYCLES - 1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [LW-1:0]    lcnt_r, lcnt_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic             load_r, load_s;
    logic             done_r, done_s;
    logic             err_r, err_s;
    logic             accept_s;
    logic             frame_end_s;

    // Ready is held low during reset so no word can be taken while state is clearing
    assign in_ready    = (state_r == S_FILL) & ~reset;
    assign accept_s    = in_valid & in_ready;
    assign frame_end_s = in_last | (cnt_r == CNT_LAST);

    assign load    = load_r;
    assign data    = data_r;
    assign done    = done_r;
    assign err_len = err_r;
    assign busy    = (state_r == S_LOAD) | (cnt_r != CNT_ZERO);

    // Next-state, word assembly and load/done/err pulse generation
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        lcnt_s  = lcnt_r;
        data_s  = data_r;
        load_s  = 1'b0;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            S_FILL: begin
                if (accept_s) begin
                    // The first word of a frame wipes the previous seed entirely
                    if (cnt_r == CNT_ZERO) begin
                        data_s = {{(WIDTH-WORD){1'b0}}, in_data};
                    end else begin
                        for (int i = 0; i < NWORDS; i++) begin
                            data_s[i*WORD +: WORD] = (cnt_r == CW'(i)) ? in_data
                                                                       : data_r[i*WORD +: WORD];
                        end
                    end
                    if (frame_end_s) begin
                        cnt_s   = CNT_ZERO;
                        lcnt_s  = LCNT_ZERO;
                        state_s = S_LOAD;
                        load_s  = 1'b1;
                        err_s   = ~in_last & (cnt_r == CNT_LAST);
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = S_FILL;
                end
            end
            S_LOAD: begin
                if (lcnt_r == LCNT_LAST) begin
                    state_s = S_FILL;
                    done_s  = 1'b1;
                end else begin
                    lcnt_s = lcnt_r + LCNT_ONE;
                    load_s = 1'b1;
                end
            end
            default: begin
                state_s = S_FILL;
                cnt_s   = CNT_ZERO;
                lcnt_s  = LCNT_ZERO;
            end
        endcase
    end

    // State and output registers; reset discards any partial or loading frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FILL;
            cnt_r   <= CNT_ZERO;
            lcnt_r  <= LCNT_ZERO;
            data_r  <= {WIDTH{1'b0}};
            load_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            lcnt_r  <= lcnt_s;
            data_r  <= data_s;
            load_r  <= load_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

endmodule

// File: tb/tb_rule110_seed_loader.sv
// Scoreboard bench for rule110_seed_loader: two instances (LOAD_CYCLES 1 and 4),
// stimulus pushes expected frames, per-instance monitors check each load phase.
module tb_rule110_seed_loader;

    typedef struct {
        logic [511:0] d;
        logic         err;
        logic         ab;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         in_valid_a [2];
    logic         in_ready_a [2];
    logic [31:0]  in_data_a  [2];
    logic         in_last_a  [2];
    logic         load_a     [2];
    logic [511:0] data_a     [2];
    logic         busy_a     [2];
    logic         done_a     [2];
    logic         err_a      [2];

    logic [511:0] mdata [2];
    int           mcnt  [2];
    exp_t         q0[$];
    exp_t         q1[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           w;
    logic [511:0] q;

    rule110_seed_loader #(.WIDTH(512), .WORD(32), .LOAD_CYCLES(1)) u_lc1 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .in_data(in_data_a[0]), .in_last(in_last_a[0]), .load(load_a[0]), .data(data_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .err_len(err_a[0]));

    rule110_seed_loader #(.WIDTH(512), .WORD(32), .LOAD_CYCLES(4)) u_lc4 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .in_data(in_data_a[1]), .in_last(in_last_a[1]), .load(load_a[1]), .data(data_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .err_len(err_a[1]));

    function automatic logic [511:0] r110(input logic [511:0] c);
        logic [511:0] l;
        logic [511:0] r;
        l = c >> 1;
        r = c << 1;
        return (c ^ r) | (c & ~l);
    endfunction

    // Behavioural automaton fed by the LOAD_CYCLES=1 instance
    always @(posedge clk) begin
        if (load_a[0]) q <= data_a[0];
        else           q <= r110(q);
    end

    task automatic checkw(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offer one word (called at a negedge); returns at the negedge after the accept edge
    task automatic send_word(input int k, input logic [31:0] d, input logic last,
                             input logic ab, output int waited);
        exp_t e;
        in_valid_a[k] = 1'b1;
        in_data_a[k]  = d;
        in_last_a[k]  = last;
        waited = 0;
        while (in_ready_a[k] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready_a[k] !== 1'b1) begin
            check1("ready_timeout", in_ready_a[k], 1'b1);
            in_valid_a[k] = 1'b0;
            return;
        end
        if (mcnt[k] == 0) mdata[k] = '0;
        mdata[k][mcnt[k]*32 +: 32] = d;
        if (last || mcnt[k] == 15) begin
            e.d   = mdata[k];
            e.err = !last && (mcnt[k] == 15);
            e.ab  = ab;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
            mcnt[k] = 0;
        end else begin
            mcnt[k]++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int k, input int n, input int exp_busy);
        for (int i = 0; i < n; i++) begin
            in_valid_a[k] = 1'b0;
            in_data_a[k]  = 'x;
            in_last_a[k]  = 1'bx;
            if (exp_busy >= 0) check1("busy", busy_a[k], exp_busy[0]);
            checkw("data_hold", data_a[k], mdata[k]);
            @(negedge clk);
        end
    endtask

    task automatic monitor(input int k);
        exp_t e;
        logic [511:0] snap;
        int lc;
        int lcnt;
        bit active;
        lc = (k == 0) ? 1 : 4;
        active = 1'b0;
        lcnt = 0;
        e.d = '0; e.err = 1'b0; e.ab = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (active) check1("abort_expected", e.ab, 1'b1);
                active = 1'b0;
            end else if (active) begin
                if (load_a[k]) begin
                    lcnt++;
                    checkw("data_stable", data_a[k], snap);
                    check1("done_in_load", done_a[k], 1'b0);
                    check1("err_late", err_a[k], 1'b0);
                end else begin
                    checki("load_len", lcnt, lc);
                    check1("done_pulse", done_a[k], 1'b1);
                    check1("err_after", err_a[k], 1'b0);
                    check1("abort_flag", e.ab, 1'b0);
                    active = 1'b0;
                end
            end else begin
                if (load_a[k]) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        check1("unexpected_load", load_a[k], 1'b0);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        checkw("frame_data", data_a[k], e.d);
                        check1("err_len", err_a[k], e.err);
                        snap   = e.d;
                        lcnt   = 1;
                        active = 1'b1;
                    end
                end else begin
                    check1("stray_done", done_a[k], 1'b0);
                    check1("stray_err", err_a[k], 1'b0);
                end
            end
        end
    endtask

    task automatic clear_models();
        for (int k = 0; k < 2; k++) begin
            mdata[k] = '0;
            mcnt[k]  = 0;
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid_a[k] = 1'b0;
            in_data_a[k]  = 'x;
            in_last_a[k]  = 1'b0;
        end
        clear_models();
        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check1("rst_ready", in_ready_a[k], 1'b0);
            check1("rst_load", load_a[k], 1'b0);
            checkw("rst_data", data_a[k], 512'h0);
            check1("rst_done", done_a[k], 1'b0);
            check1("rst_err", err_a[k], 1'b0);
            check1("rst_busy", busy_a[k], 1'b0);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        check1("ready_after_rst0", in_ready_a[0], 1'b1);
        check1("ready_after_rst1", in_ready_a[1], 1'b1);

        // single-word seed, then rule-110 step in the automaton
        send_word(0, 32'h0000_0001, 1'b1, 1'b0, w);
        check1("t1_ready_low", in_ready_a[0], 1'b0);
        checkw("t1_data", data_a[0], 512'h1);
        idle(0, 1, 1);
        idle(0, 1, 0);
        checkw("t1_q_rule110", q, 512'h3);

        // full 16-word frame, in_valid held high
        for (int i = 0; i < 16; i++) send_word(0, 32'(i), (i == 15), 1'b0, w);
        check1("t2_ready_low", in_ready_a[0], 1'b0);
        checkw("t2_low_word", {480'h0, data_a[0][31:0]}, 512'h0);
        checkw("t2_top_word", {480'h0, data_a[0][511:480]}, 512'hF);
        idle(0, 3, -1);

        // 16 words without in_last, then a 17th word starts a fresh frame
        for (int i = 0; i < 16; i++) send_word(0, 32'h100 + 32'(i), 1'b0, 1'b0, w);
        send_word(0, 32'hAAAA_AAAA, 1'b1, 1'b0, w);
        checkw("t3_new_frame", data_a[0], 512'hAAAA_AAAA);
        idle(0, 3, -1);

        // back-to-back frames, second offered while the first is loading
        send_word(0, 32'h7, 1'b1, 1'b0, w);
        send_word(0, 32'hFFFF_FFFF, 1'b0, 1'b0, w);
        checki("t4_wait_cycles", w, 1);
        send_word(0, 32'h1, 1'b1, 1'b0, w);
        checkw("t4_data", data_a[0], 512'h1_FFFF_FFFF);
        idle(0, 3, -1);

        // gaps between words, LOAD_CYCLES=4 instance
        send_word(1, 32'h11, 1'b0, 1'b0, w);
        idle(1, 3, 1);
        send_word(1, 32'h22, 1'b0, 1'b0, w);
        idle(1, 3, 1);
        send_word(1, 32'h33, 1'b1, 1'b0, w);
        check1("t5_ready_low", in_ready_a[1], 1'b0);
        checkw("t5_data", data_a[1], {416'h0, 32'h33, 32'h22, 32'h11});
        idle(1, 4, 1);
        idle(1, 1, 0);
        idle(1, 2, -1);

        // reset in the middle of a frame
        for (int i = 0; i < 5; i++) send_word(0, 32'(i + 1), 1'b0, 1'b0, w);
        in_valid_a[0] = 1'b0;
        #2 reset = 1'b1;
        #1;
        check1("t6_ready_rst", in_ready_a[0], 1'b0);
        checkw("t6_data_rst", data_a[0], 512'h0);
        clear_models();
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check1("t6_busy_clear", busy_a[0], 1'b0);

        // reset during a load phase
        send_word(0, 32'h5, 1'b1, 1'b1, w);
        check1("t6_load_high", load_a[0], 1'b1);
        in_valid_a[0] = 1'b0;
        #2 reset = 1'b1;
        #1;
        check1("t6_load_drop", load_a[0], 1'b0);
        checkw("t6_data_clear", data_a[0], 512'h0);
        clear_models();
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        idle(0, 3, 0);
        send_word(0, 32'h9, 1'b1, 1'b0, w);
        checkw("t6_restart", data_a[0], 512'h9);
        idle(0, 3, -1);

        repeat (5) @(negedge clk);
        checki("q0_empty", q0.size(), 0);
        checki("q1_empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
